seg_scan: RTL and testbench

Time-multiplexed 6-digit seven-segment display driver for the digital clock. It accepts the six per-digit segment patterns produced by the hour/min/sec converters (sec ones/tens, min ones/tens, hour ones/tens) and drives one shared active-low segment bus plus six active-low digit anodes. Each digit is lit in turn with a blanking guard interval. It sits between the converter blocks and the board pins.

---
 rtl/seg_pkg.sv | 51 +++++
 rtl/scan_tick_gen.sv | 47 ++++
 rtl/seg_scan.sv | 139 +++++++++++++
 tb/tb_seg_scan.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and payload types for the seven-segment display path.
// Glyphs are active-low with bit 0 = segment a.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned DIGIT_W    = 3;

   localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = 6'h3F;

   localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;

   // Registered pin-side payload of the scanner.
   typedef struct packed {
      logic [SEG_W-1:0]      seg;
      logic [NUM_DIGITS-1:0] an;
      logic                  dp;
   } scan_out_t;

   localparam scan_out_t OUT_RESET = '{seg: SEG_BLANK, an: AN_OFF, dp: 1'b1};

   // Decimal value to glyph; out-of-range values map to a blank digit.
   function automatic logic [SEG_W-1:0] glyph(input logic [3:0] val);
      logic [SEG_W-1:0] g;
      case (val)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: wrapping div_cnt with registered slot_end
// (div_cnt == REFRESH_DIV-1) and in_blank (div_cnt < BLANK_CYCLES) flags.
module scan_tick_gen #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic clk,
   input  logic rst_n,
   output logic slot_end_o,
   output logic in_blank_o
);

   localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             slot_end_q, slot_end_d;
   logic             in_blank_q, in_blank_d;

   // Flags are computed from the next count so they line up with div_q.
   always_comb begin
      div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      slot_end_d = (div_d == DIV_LAST);
   end

   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_d = 1'b0;
   end else begin : g_blank
      assign in_blank_d = (div_d < DIV_W'(BLANK_CYCLES));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         slot_end_q <= 1'b0;
         in_blank_q <= (BLANK_CYCLES != 0);
      end else begin
         div_q      <= div_d;
         slot_end_q <= slot_end_d;
         in_blank_q <= in_blank_d;
      end
   end

   assign slot_end_o = slot_end_q;
   assign in_blank_o = in_blank_q;

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed seven-segment driver with frame-synchronous shadow capture.
// Optional separator blink on dp enabled by defining SEG_SCAN_DP_BLINK_EN.
module seg_scan
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [SEG_W-1:0]      seg_d0_i,
   input  logic [SEG_W-1:0]      seg_d1_i,
   input  logic [SEG_W-1:0]      seg_d2_i,
   input  logic [SEG_W-1:0]      seg_d3_i,
   input  logic [SEG_W-1:0]      seg_d4_i,
   input  logic [SEG_W-1:0]      seg_d5_i,
   output logic [SEG_W-1:0]      seg_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic                  dp_o
);

   localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

   if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV || BLINK_FRAMES < 1) begin : g_bad_param
      $error("seg_scan: illegal REFRESH_DIV/BLANK_CYCLES/BLINK_FRAMES");
   end

   logic                 slot_end;
   logic                 in_blank;
   logic                 frame_end;
   logic                 lit;
   logic                 dp_n_c;
   logic [DIGIT_W-1:0]   digit_q, digit_d;
   logic [SEG_W-1:0]     seg_in   [NUM_DIGITS];
   logic [SEG_W-1:0]     shadow_q [NUM_DIGITS];
   logic [SEG_W-1:0]     shadow_d [NUM_DIGITS];
   scan_out_t            out_q, out_d;

   scan_tick_gen #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot_end_o (slot_end),
      .in_blank_o (in_blank)
   );

   always_comb begin
      seg_in[0] = seg_d0_i;
      seg_in[1] = seg_d1_i;
      seg_in[2] = seg_d2_i;
      seg_in[3] = seg_d3_i;
      seg_in[4] = seg_d4_i;
      seg_in[5] = seg_d5_i;
   end

   assign frame_end = slot_end && (digit_q == DIGIT_LAST);
   assign lit       = en_i && !in_blank;

   // Digit sequencing and tear-free shadow capture at the frame boundary.
   always_comb begin
      digit_d  = digit_q;
      shadow_d = shadow_q;
      if (slot_end) begin
         digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIGIT_W'(1);
      end
      if (frame_end) begin
         shadow_d = seg_in;
      end
   end

`ifdef SEG_SCAN_DP_BLINK_EN
   localparam int unsigned FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [FRM_W-1:0] frm_q, frm_d;
   logic             blink_q, blink_d;

   // Frame counter flips the blink phase every BLINK_FRAMES frames.
   always_comb begin
      frm_d   = frm_q;
      blink_d = blink_q;
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            blink_d = ~blink_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         frm_q   <= frm_d;
         blink_q <= blink_d;
      end
   end

   // Separator dots sit after the hour-ones and minute-ones digits.
   assign dp_n_c = ~(blink_q & lit &
                     ((digit_q == DIGIT_W'(2)) | (digit_q == DIGIT_W'(4))));
`else
   assign dp_n_c = 1'b1;
`endif

   // Output mux; registered so pins see state with one cycle of latency.
   always_comb begin
      out_d     = OUT_RESET;
      out_d.dp  = dp_n_c;
      if (lit) begin
         out_d.seg = shadow_q[digit_q];
         out_d.an  = ~(NUM_DIGITS'(1) << digit_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q  <= '0;
         shadow_q <= '{default: SEG_BLANK};
         out_q    <= OUT_RESET;
      end else begin
         digit_q  <= digit_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign seg_o = out_q.seg;
   assign an_o  = out_q.an;
   assign dp_o  = out_q.dp;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: time-indexed display model checked every cycle plus
// hand-computed pins for reset, mapping, tearing, enable, async reset and blink.
module tb_seg_scan;
   import seg_pkg::*;

   localparam int RDIV  = 8;
   localparam int BLANK = 2;
   localparam int BFR   = 2;
   localparam int FRAME = RDIV * 6;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b1;
   logic [6:0] d [6] = '{default: 7'h40};
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;

   int checks = 0;
   int errors = 0;

   seg_scan #(
      .REFRESH_DIV  (RDIV),
      .BLANK_CYCLES (BLANK),
      .BLINK_FRAMES (BFR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .seg_d0_i (d[0]),
      .seg_d1_i (d[1]),
      .seg_d2_i (d[2]),
      .seg_d3_i (d[3]),
      .seg_d4_i (d[4]),
      .seg_d5_i (d[5]),
      .seg_o    (seg),
      .an_o     (an),
      .dp_o     (dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: state index n counts cycles since reset release; slot, digit and
   // frame follow by division, shadows are the inputs seen at each frame's last cycle.
   int         m_n = 0;
   logic [6:0] m_sh [6] = '{default: 7'h7F};
   logic [6:0] e_seg = 7'h7F;
   logic [5:0] e_an  = 6'h3F;
   logic       e_dp  = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n   = 0;
         for (int i = 0; i < 6; i++) m_sh[i] = 7'h7F;
         e_seg = 7'h7F;
         e_an  = 6'h3F;
         e_dp  = 1'b1;
      end else begin : model_step
         int   div;
         int   frm;
         int   dig;
         logic lit;
         div   = m_n % RDIV;
         dig   = (m_n / RDIV) % 6;
         frm   = m_n / FRAME;
         lit   = en && (div >= BLANK);
         e_seg = lit ? m_sh[dig] : 7'h7F;
         e_an  = lit ? 6'(~(6'b1 << dig)) : 6'h3F;
`ifdef SEG_SCAN_DP_BLINK_EN
         e_dp  = !(lit && ((frm / BFR) % 2 == 1) && (dig == 2 || dig == 4));
`else
         e_dp  = 1'b1;
`endif
         if (m_n % FRAME == FRAME - 1) begin
            for (int i = 0; i < 6; i++) m_sh[i] = d[i];
         end
         m_n++;
      end
   end

   always @(negedge clk) begin
      check("cyc_seg", 32'(seg), 32'(e_seg));
      check("cyc_an",  32'(an),  32'(e_an));
      check("cyc_dp",  32'(dp),  32'(e_dp));
   end

   // Advance to the negedge at which the outputs show model state index s.
   task automatic goto_state(input int s);
      int g;
      g = 0;
      @(negedge clk);
      while ((m_n - 1) != s && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 3000) begin
         errors++;
         checks++;
         $display("FAIL goto_state(%0d): timed out at model index %0d", s, m_n - 1);
      end
   endtask

   logic [6:0] exp_gl [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
   logic [5:0] exp_an [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

   initial begin
      repeat (3) @(negedge clk);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an",  32'(an),  32'h3F);
      check("rst_dp",  32'(dp),  32'h1);
      rst_n = 1'b1;

      goto_state(47);  check("f0_blank_seg", 32'(seg), 32'h7F);
      goto_state(48);  check("f1_guard_an", 32'(an), 32'h3F);
      goto_state(50);
      for (int i = 0; i < 6; i++) d[i] = glyph(4'(i));
      goto_state(66);  check("f1_d2_an", 32'(an), 32'h3B);
                       check("f1_d2_seg", 32'(seg), 32'h40);

      for (int i = 0; i < 6; i++) begin
         goto_state(96 + 8 * i + 2);
         check("map_an",  32'(an),  32'(exp_an[i]));
         check("map_seg", 32'(seg), 32'(exp_gl[i]));
      end

      goto_state(140);
      for (int i = 0; i < 6; i++) d[i] = 7'h40;
      goto_state(155); d[3] = 7'h24;
      goto_state(170); check("tear_old_an", 32'(an), 32'h37);
                       check("tear_old_seg", 32'(seg), 32'h40);
      goto_state(218); check("tear_new_seg", 32'(seg), 32'h24);

      goto_state(230); en = 1'b0;
      goto_state(231); check("en_off_an", 32'(an), 32'h3F);
                       check("en_off_seg", 32'(seg), 32'h7F);
      goto_state(250); en = 1'b1;
      goto_state(260); check("en_resume_an", 32'(an), 32'h3B);
                       check("en_resume_seg", 32'(seg), 32'h40);

      goto_state(324);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_seg", 32'(seg), 32'h7F);
      check("arst_an",  32'(an),  32'h3F);
      check("arst_dp",  32'(dp),  32'h1);
      #2 rst_n = 1'b1;

      goto_state(1);   check("post_guard_an", 32'(an), 32'h3F);
      goto_state(10);  check("post_f0_an", 32'(an), 32'h3D);
                       check("post_f0_seg", 32'(seg), 32'h7F);
      goto_state(58);  check("post_f1_seg", 32'(seg), 32'h40);
`ifdef SEG_SCAN_DP_BLINK_EN
      goto_state(115); check("blink_f2_d2", 32'(dp), 32'h0);
      goto_state(123); check("blink_f2_d3", 32'(dp), 32'h1);
      goto_state(163); check("blink_f3_d2", 32'(dp), 32'h0);
      goto_state(211); check("blink_f4_d2", 32'(dp), 32'h1);
`else
      goto_state(115); check("dp_const_d2", 32'(dp), 32'h1);
      goto_state(163); check("dp_const_f3", 32'(dp), 32'h1);
`endif
      goto_state(250);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
